// File: rtl/maze_player_ctrl.sv
// maze_player_ctrl
// Player-movement controller for a grid maze. It turns four raw push buttons
// into single move requests, asks the maze map whether the target cell is a
// wall, and updates the player position and move counter when the cell is free.
//
// Configuration macro: MAZE_PLAYER_WRAP_EN
//   undefined (default) : a move off the grid edge bumps and issues no query
//   defined             : a move off the grid edge wraps to the opposite edge
//
// Ports
//   iCLK      in   1  system clock
//   iRST_N    in   1  synchronous active-low reset
//   iDIR_N    in   4  raw buttons, active-low: [0] right [1] left [2] down [3] up
//   oQ_VALID  out  1  wall-query request to the maze map
//   oQ_X/Y    out  5  cell being queried
//   iQ_READY  in   1  map accepts the query and returns iQ_WALL this cycle
//   iQ_WALL   in   1  queried cell is a wall (valid with iQ_READY)
//   oPX/oPY   out  5  current player cell
//   oMOVES    out 16  successful move count, saturating
//   oBUMP     out  1  one-cycle pulse when a move is rejected
//   oAT_GOAL  out  1  player is on the goal cell
module maze_player_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int GRID_W          = 32,
  parameter int GRID_H          = 24,
  parameter int START_X         = 0,
  parameter int START_Y         = 0,
  parameter int GOAL_X          = 31,
  parameter int GOAL_Y          = 23
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic [3:0]  iDIR_N,
  output logic        oQ_VALID,
  output logic [4:0]  oQ_X,
  output logic [4:0]  oQ_Y,
  input  logic        iQ_READY,
  input  logic        iQ_WALL,
  output logic [4:0]  oPX,
  output logic [4:0]  oPY,
  output logic [15:0] oMOVES,
  output logic        oBUMP,
  output logic        oAT_GOAL
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [4:0] MAX_X   = 5'(GRID_W - 1);
  localparam logic [4:0] MAX_Y   = 5'(GRID_H - 1);
  localparam logic [4:0] START_XV = 5'(START_X);
  localparam logic [4:0] START_YV = 5'(START_Y);
  localparam logic [4:0] GOAL_XV  = 5'(GOAL_X);
  localparam logic [4:0] GOAL_YV  = 5'(GOAL_Y);
`ifdef MAZE_PLAYER_WRAP_EN
  localparam logic WRAP_EN = 1'b1;
`else
  localparam logic WRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, QUERY, MOVE} stateT;

  stateT            r_state, w_stateNext;
  logic [3:0]       r_sync1, r_sync2, r_stable, r_evt;
  logic [CW-1:0]    r_cnt [4];
  logic [4:0]       r_tgtX, r_tgtY, r_px, r_py;
  logic [15:0]      r_moves;
  logic             r_bump, r_atGoal;
  logic [4:0]       w_tgtX, w_tgtY;
  logic             w_anyEvt, w_offGrid, w_blocked, w_loadTgt, w_bumpSet;

  // Synchronize the raw buttons, then debounce each one: the stable level only
  // flips after the synchronized input has disagreed with it for
  // DEBOUNCE_CYCLES consecutive cycles. A press event is a registered pulse
  // emitted exactly when the stable level flips to pressed (low).
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      r_sync1  <= 4'hF;
      r_sync2  <= 4'hF;
      r_stable <= 4'hF;
      r_evt    <= 4'h0;
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= iDIR_N;
      r_sync2 <= r_sync1;
      r_evt   <= 4'h0;
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] != r_stable[i]) begin
          if (r_cnt[i] == CNT_MAX) begin
            r_stable[i] <= r_sync2[i];
            r_evt[i]    <= ~r_sync2[i];
            r_cnt[i]    <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + CW'(1);
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  // Pick one event (up > down > left > right) and work out the neighbouring
  // cell. The wrapped coordinate is always produced; w_offGrid tells the FSM
  // whether the move crossed an edge.
  always_comb begin
    w_anyEvt  = |r_evt;
    w_tgtX    = r_px;
    w_tgtY    = r_py;
    w_offGrid = 1'b0;
    if (r_evt[3]) begin
      if (r_py == 5'd0) begin w_offGrid = 1'b1; w_tgtY = MAX_Y; end
      else w_tgtY = r_py - 5'd1;
    end else if (r_evt[2]) begin
      if (r_py == MAX_Y) begin w_offGrid = 1'b1; w_tgtY = 5'd0; end
      else w_tgtY = r_py + 5'd1;
    end else if (r_evt[1]) begin
      if (r_px == 5'd0) begin w_offGrid = 1'b1; w_tgtX = MAX_X; end
      else w_tgtX = r_px - 5'd1;
    end else if (r_evt[0]) begin
      if (r_px == MAX_X) begin w_offGrid = 1'b1; w_tgtX = 5'd0; end
      else w_tgtX = r_px + 5'd1;
    end
    w_blocked = w_offGrid & ~WRAP_EN;
  end

  // FSM state register.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) r_state <= IDLE;
    else         r_state <= w_stateNext;
  end

  // Next-state logic. Events outside IDLE, or while on the goal, simply fall
  // on the floor because they are single-cycle pulses that are never stored.
  always_comb begin
    w_stateNext = r_state;
    w_loadTgt   = 1'b0;
    w_bumpSet   = 1'b0;
    oQ_VALID    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_anyEvt && !r_atGoal) begin
          if (w_blocked) begin
            w_bumpSet = 1'b1;
          end else begin
            w_loadTgt   = 1'b1;
            w_stateNext = QUERY;
          end
        end
      end
      QUERY: begin
        oQ_VALID = 1'b1;
        if (iQ_READY) begin
          if (iQ_WALL) begin
            w_bumpSet   = 1'b1;
            w_stateNext = IDLE;
          end else begin
            w_stateNext = MOVE;
          end
        end
      end
      MOVE:    w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // Datapath: latch the target on entry to QUERY, commit it in MOVE. The goal
  // flag is computed from the value being loaded so it tracks oPX/oPY exactly.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      r_tgtX   <= START_XV;
      r_tgtY   <= START_YV;
      r_px     <= START_XV;
      r_py     <= START_YV;
      r_moves  <= 16'd0;
      r_bump   <= 1'b0;
      r_atGoal <= (START_XV == GOAL_XV) && (START_YV == GOAL_YV);
    end else begin
      r_bump <= w_bumpSet;
      if (w_loadTgt) begin
        r_tgtX <= w_tgtX;
        r_tgtY <= w_tgtY;
      end
      if (r_state == MOVE) begin
        r_px     <= r_tgtX;
        r_py     <= r_tgtY;
        r_atGoal <= (r_tgtX == GOAL_XV) && (r_tgtY == GOAL_YV);
        if (r_moves != 16'hFFFF) r_moves <= r_moves + 16'd1;
      end
    end
  end

  assign oQ_X     = r_tgtX;
  assign oQ_Y     = r_tgtY;
  assign oPX      = r_px;
  assign oPY      = r_py;
  assign oMOVES   = r_moves;
  assign oBUMP    = r_bump;
  assign oAT_GOAL = r_atGoal;

endmodule
